// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Main control FSM for a multicycle RV32 subset core. It supports lw, sw,
// R-type, I-type ALU, jal and beq. Each state drives a fixed set of datapath
// controls. These controls are registered together with the state, so they
// change only on clock edges.
//
// A few outputs are combinational:
//   - PCWrite combines the state's PC update with (Branch & Zero).
//   - ImmSrc is decoded from op in every state.
//   - Illegal flags an unknown opcode during Decode.
//
// Optional feature (macro MC_MEM_WAIT_EN):
//   When defined, a MemReady input is added. Fetch, MemRead and MemWrite then
//   stall until MemReady is 1. When undefined, there is no MemReady port and
//   memory is treated as always ready.
//
// Ports:
//   clk        in   1  clock; all state updates on the rising edge
//   reset_n    in   1  asynchronous active-low reset
//   op         in   7  instruction opcode (instr[6:0]), valid from Decode on
//   Zero       in   1  ALU zero flag
//   MemReady   in   1  memory access completes this cycle (MC_MEM_WAIT_EN only)
//   PCWrite    out  1  PC register write enable
//   AdrSrc     out  1  memory address select (0: PC, 1: ALU result)
//   MemWrite   out  1  data memory write enable
//   IRWrite    out  1  instruction register write enable
//   RegWrite   out  1  register file write enable
//   ResultSrc  out  2  result mux select
//   ALUSrcA    out  2  ALU operand A select
//   ALUSrcB    out  2  ALU operand B select
//   ALUOp      out  2  to ALU decoder
//   ImmSrc     out  2  immediate format select
//   Illegal    out  1  unknown opcode seen in Decode
// -----------------------------------------------------------------------------
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       Zero,
`ifdef MC_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_ALUWB,
    S_EXECUTEI,
    S_JAL,
    S_BEQ
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore outputs of each state. Any field not set here is 0.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.pcupdate  = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        c.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      S_EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
      end
      S_JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b01;
        c.branch  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  logic   mem_ready;
  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   op_known;
  logic   fetch_hold;
  logic   pc_update;

`ifdef MC_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only lw and sw can reach MemAdr.
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // The control word is loaded with the outputs of the state being entered,
  // so it always lines up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // During a stalled Fetch, neither the IR nor the PC may advance. The PC
  // update made by JAL is not subject to this stall.
  assign fetch_hold = (state_q == S_FETCH) && !mem_ready;
  assign pc_update  = ctrl_q.pcupdate && !fetch_hold;

  // While reset is low, the register holds the Fetch control word. The write
  // enables are therefore qualified with reset_n, so nothing is written
  // during reset.
  assign PCWrite   = reset_n && (pc_update || (ctrl_q.branch && Zero));
  assign IRWrite   = reset_n && ctrl_q.irwrite && mem_ready;
  assign MemWrite  = reset_n && ctrl_q.memwrite;
  assign RegWrite  = reset_n && ctrl_q.regwrite;
  assign Illegal   = reset_n && (state_q == S_DECODE) && !op_known;

  assign AdrSrc    = ctrl_q.adrsrc;
  assign ResultSrc = ctrl_q.resultsrc;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  assign ALUOp     = ctrl_q.aluop;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//
// Directed bench for mc_controller. The outputs are packed into one 16-bit
// word:
//   {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//    ALUSrcB, ALUOp, ImmSrc, Illegal}
// Each cycle this word is compared with hand-written per-state constants,
// with the ImmSrc bits for the current opcode OR-ed in.
// -----------------------------------------------------------------------------
module tb_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
`ifdef MC_MEM_WAIT_EN
  logic       MemReady;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output words, by state.
  //                                    P A M I R RS SA SB AO IM L
  localparam logic [15:0] E_RST    = 16'b0_0_0_0_0_10_00_10_00_00_0;
  localparam logic [15:0] E_FETCH  = 16'b1_0_0_1_0_10_00_10_00_00_0;
  localparam logic [15:0] E_DECODE = 16'b0_0_0_0_0_00_01_01_00_00_0;
  localparam logic [15:0] E_MEMADR = 16'b0_0_0_0_0_00_10_01_00_00_0;
  localparam logic [15:0] E_MEMRD  = 16'b0_1_0_0_0_00_00_00_00_00_0;
  localparam logic [15:0] E_MEMWB  = 16'b0_0_0_0_1_01_00_00_00_00_0;
  localparam logic [15:0] E_MEMWR  = 16'b0_1_1_0_0_00_00_00_00_00_0;
  localparam logic [15:0] E_EXECR  = 16'b0_0_0_0_0_00_10_00_10_00_0;
  localparam logic [15:0] E_EXECI  = 16'b0_0_0_0_0_00_10_01_10_00_0;
  localparam logic [15:0] E_ALUWB  = 16'b0_0_0_0_1_00_00_00_00_00_0;
  localparam logic [15:0] E_JAL    = 16'b1_0_0_0_0_00_01_10_00_00_0;
  localparam logic [15:0] E_BEQ    = 16'b0_0_0_0_0_00_10_00_01_00_0;
  localparam logic [15:0] PCW      = 16'h8000;
  localparam logic [15:0] ILL      = 16'h0001;
  localparam logic [15:0] IMM_S    = 16'h0002;
  localparam logic [15:0] IMM_B    = 16'h0004;
  localparam logic [15:0] IMM_J    = 16'h0006;

  logic [15:0] outs;
  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal};

  mc_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .Zero      (Zero),
`ifdef MC_MEM_WAIT_EN
    .MemReady  (MemReady),
`endif
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .Illegal   (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step_check(input string tag, input logic [15:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, outs, exp);
  endtask

  initial begin
    reset_n = 1'b1;
    op      = 7'b0000011;
    Zero    = 1'b0;
`ifdef MC_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
    #2 reset_n = 1'b0;
    #1 check_eq("rst_async", outs, E_RST);
    for (int i = 0; i < 3; i++) step_check("rst_hold", E_RST);

    // lw: 5 cycles
    #1 reset_n = 1'b1;
    #1 check_eq("lw_fetch", outs, E_FETCH);
    step_check("lw_decode", E_DECODE);
    step_check("lw_memadr", E_MEMADR);
    step_check("lw_memread", E_MEMRD);
    step_check("lw_memwb", E_MEMWB);
    step_check("lw_done", E_FETCH);

    // beq, branch taken
    op = 7'b1100011; Zero = 1'b1;
    #1 check_eq("beq1_fetch", outs, E_FETCH | IMM_B);
    step_check("beq1_decode", E_DECODE | IMM_B);
    step_check("beq1_beq", E_BEQ | IMM_B | PCW);
    step_check("beq1_done", E_FETCH | IMM_B);

    // beq, not taken; Zero is also toggled inside BEQ to show PCWrite follows it
    Zero = 1'b0;
    step_check("beq0_decode", E_DECODE | IMM_B);
    step_check("beq0_beq", E_BEQ | IMM_B);
    Zero = 1'b1;
    #1 check_eq("beq_zero_comb", outs, E_BEQ | IMM_B | PCW);
    Zero = 1'b0;
    step_check("beq0_done", E_FETCH | IMM_B);

    // illegal opcode: 2 cycles
    op = 7'b1111111;
    #1 check_eq("ill_fetch", outs, E_FETCH);
    step_check("ill_decode", E_DECODE | ILL);
    step_check("ill_done", E_FETCH);

    // sw: 4 cycles
    op = 7'b0100011;
    step_check("sw_decode", E_DECODE | IMM_S);
    step_check("sw_memadr", E_MEMADR | IMM_S);
    step_check("sw_memwrite", E_MEMWR | IMM_S);
    step_check("sw_done", E_FETCH | IMM_S);

    // R-type: 4 cycles
    op = 7'b0110011;
    step_check("r_decode", E_DECODE);
    step_check("r_exec", E_EXECR);
    step_check("r_aluwb", E_ALUWB);
    step_check("r_done", E_FETCH);

    // I-type: 4 cycles
    op = 7'b0010011;
    step_check("i_decode", E_DECODE);
    step_check("i_exec", E_EXECI);
    step_check("i_aluwb", E_ALUWB);
    step_check("i_done", E_FETCH);

    // jal: 4 cycles
    op = 7'b1101111;
    step_check("jal_decode", E_DECODE | IMM_J);
    step_check("jal_jal", E_JAL | IMM_J);
    step_check("jal_aluwb", E_ALUWB | IMM_J);
    step_check("jal_done", E_FETCH | IMM_J);

    // sw aborted by reset during MemAdr
    op = 7'b0100011;
    step_check("swr_decode", E_DECODE | IMM_S);
    step_check("swr_memadr", E_MEMADR | IMM_S);
    #2 reset_n = 1'b0;
    #1 check_eq("swr_rst_now", outs, E_RST | IMM_S);
    step_check("swr_rst_hold", E_RST | IMM_S);
    #2 reset_n = 1'b1;
    #1 check_eq("swr_refetch", outs, E_FETCH | IMM_S);
    step_check("swr_decode2", E_DECODE | IMM_S);

`ifdef MC_MEM_WAIT_EN
    // finish this sw, then stall the next Fetch
    step_check("w_memadr", E_MEMADR | IMM_S);
    step_check("w_memwrite", E_MEMWR | IMM_S);
    MemReady = 1'b0;
    #1 check_eq("w_memwrite_hold", outs, E_MEMWR | IMM_S);
    step_check("w_memwrite_hold2", E_MEMWR | IMM_S);
    MemReady = 1'b1;
    step_check("w_fetch", E_FETCH | IMM_S);
    MemReady = 1'b0;
    #1 check_eq("w_fetch_stall", outs, E_RST | IMM_S);
    for (int i = 0; i < 4; i++) step_check("w_fetch_held", E_RST | IMM_S);
    MemReady = 1'b1;
    #1 check_eq("w_fetch_ready", outs, E_FETCH | IMM_S);
    step_check("w_decode", E_DECODE | IMM_S);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
